cplx_calc_p: RTL and testbench

CPLX_CALC_P -- requirements
Module: cplx_calc_p

---
 rtl/cplx_calc_p.sv | 216 +++++++++++++++++++++
 tb/tb_cplx_calc_p.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cplx_calc_p.sv
// cplx_calc_p: streaming complex add/sub/mul/conj-mul on one shared MAC.
//
// A frame is four signed W-bit words (Are, Aim, Bre, Bim). MODE is taken
// with the first word. The result leaves as two OW-bit words, real part
// first, each held until OUT_READY accepts it.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for Are; MODE is captured with it
//   LOAD    | collecting Aim, Bre, Bim
//   CALC    | one MAC step per cycle (2 add/sub, 4 mul), then write-back
//   OUT     | real part offered, then imaginary part, one per handshake
//
// The CALC write-back cycle moves res_re onto OUT. As a result, OUT_VALID
// rises 3 edges after the 4th word for add/sub and 5 edges after it for mul.

module cplx_calc_p #(
    parameter int W = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [1:0]    MODE,
    input  logic [W-1:0]  IN,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [2*W:0]  OUT
);

    localparam int OW = 2*W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t          state;
    logic [1:0]      word_cnt;
    logic [1:0]      mode_q;
    logic [W-1:0]    are;
    logic [W-1:0]    aim;
    logic [W-1:0]    bre;
    logic [W-1:0]    bim;
    logic [OW-1:0]   acc;
    logic [OW-1:0]   res_re;
    logic [OW-1:0]   res_im;
    logic [2:0]      step;
    logic [2:0]      calc_last;
    logic            out_im;
    logic            in_accept;

    // W+1-bit operand views, so that negating -2^(W-1) stays representable
    logic signed [W:0]    are_x;
    logic signed [W:0]    aim_x;
    logic signed [W:0]    bre_x;
    logic signed [W:0]    bim_x;
    logic signed [W:0]    one_x;

    // MAC operands and result: Acc = C + X*Y
    logic signed [W:0]    mac_x;
    logic signed [W:0]    mac_y;
    logic signed [OW-1:0] mac_c;
    logic signed [OW-1:0] x_ext;
    logic signed [OW-1:0] y_ext;
    logic signed [OW-1:0] mac_sum;

    assign are_x = {are[W-1], are};
    assign aim_x = {aim[W-1], aim};
    assign bre_x = {bre[W-1], bre};
    assign bim_x = {bim[W-1], bim};
    assign one_x = {{W{1'b0}}, 1'b1};

    assign in_accept = IN_VALID && IN_READY;

    // add/sub need one MAC step per component; mul/conj-mul need two
    assign calc_last = mode_q[1] ? 3'd4 : 3'd2;

    // The true product always fits in OW bits, so OW-wide arithmetic is exact
    assign x_ext   = {{W{mac_x[W]}}, mac_x};
    assign y_ext   = {{W{mac_y[W]}}, mac_y};
    assign mac_sum = mac_c + x_ext * y_ext;

    // Select MAC operands for the current CALC step
    always_comb begin
        mac_x = '0;
        mac_y = '0;
        mac_c = '0;
        if (!mode_q[1]) begin
            // add/sub: component = A + B*(+/-1)
            mac_y = mode_q[0] ? -one_x : one_x;
            if (step[0] == 1'b0) begin
                mac_c = {{(OW-W){are[W-1]}}, are};
                mac_x = bre_x;
            end else begin
                mac_c = {{(OW-W){aim[W-1]}}, aim};
                mac_x = bim_x;
            end
        end else begin
            case (step[1:0])
                2'd0: begin
                    mac_x = are_x;
                    mac_y = bre_x;
                end
                2'd1: begin
                    // mul: -Aim*Bim, conj-mul: +Aim*Bim
                    mac_c = acc;
                    mac_x = aim_x;
                    mac_y = mode_q[0] ? bim_x : -bim_x;
                end
                2'd2: begin
                    // mul: +Are*Bim, conj-mul: -Are*Bim
                    mac_x = are_x;
                    mac_y = mode_q[0] ? -bim_x : bim_x;
                end
                default: begin
                    mac_c = acc;
                    mac_x = aim_x;
                    mac_y = bre_x;
                end
            endcase
        end
    end

    // Frame FSM: operand capture, MAC sequencing and output handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            word_cnt  <= '0;
            mode_q    <= '0;
            are       <= '0;
            aim       <= '0;
            bre       <= '0;
            bim       <= '0;
            acc       <= '0;
            res_re    <= '0;
            res_im    <= '0;
            step      <= '0;
            out_im    <= 1'b0;
            IN_READY  <= 1'b1;
            OUT_VALID <= 1'b0;
            OUT       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_accept) begin
                        are      <= IN;
                        mode_q   <= MODE;
                        word_cnt <= 2'd1;
                        state    <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (in_accept) begin
                        word_cnt <= word_cnt + 2'd1;
                        case (word_cnt)
                            2'd1:    aim <= IN;
                            2'd2:    bre <= IN;
                            default: begin
                                bim      <= IN;
                                step     <= '0;
                                IN_READY <= 1'b0;
                                state    <= ST_CALC;
                            end
                        endcase
                    end
                end

                ST_CALC: begin
                    if (step == calc_last) begin
                        OUT_VALID <= 1'b1;
                        OUT       <= res_re;
                        out_im    <= 1'b0;
                        state     <= ST_OUT;
                    end else begin
                        step <= step + 3'd1;
                        if (!mode_q[1]) begin
                            if (step[0] == 1'b0) begin
                                res_re <= mac_sum;
                            end else begin
                                res_im <= mac_sum;
                            end
                        end else begin
                            case (step[1:0])
                                2'd1:    res_re <= mac_sum;
                                2'd3:    res_im <= mac_sum;
                                default: acc    <= mac_sum;
                            endcase
                        end
                    end
                end

                ST_OUT: begin
                    if (OUT_READY) begin
                        if (!out_im) begin
                            OUT    <= res_im;
                            out_im <= 1'b1;
                        end else begin
                            OUT       <= '0;
                            OUT_VALID <= 1'b0;
                            out_im    <= 1'b0;
                            IN_READY  <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cplx_calc_p.sv
// Bench for cplx_calc_p (W=8): directed frames, a result queue from a plain
// complex-arithmetic model, and a per-cycle output checker.

module tb_cplx_calc_p;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [1:0]  MODE = 2'b00;
    logic [7:0]  in_d = 8'h00;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic [16:0] out_d;

    cplx_calc_p #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .MODE      (MODE),
        .IN        (in_d),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT       (out_d)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_q[$];
    int done_cnt = 0;
    int valid_cycles = 0;
    int first_valid_cyc = -1;
    int got_re = 0;
    int got_im = 0;
    bit prev_valid = 1'b0;
    bit prev_stall = 1'b0;
    bit prev_hs_re = 1'b0;
    bit out_idx = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference complex arithmetic
    function automatic void model(input int m, input int ar, input int ai,
                                  input int br, input int bi,
                                  output int re, output int im);
        case (m)
            0: begin re = ar + br;           im = ai + bi;           end
            1: begin re = ar - br;           im = ai - bi;           end
            2: begin re = ar * br - ai * bi; im = ar * bi + ai * br; end
            default: begin re = ar * br + ai * bi; im = ai * br - ar * bi; end
        endcase
    endfunction

    // Output checker, sampled on the falling edge
    always @(negedge clk) begin
        int v;
        bit hs;
        if (rst) begin
            prev_valid = 1'b0;
            prev_stall = 1'b0;
            prev_hs_re = 1'b0;
            out_idx    = 1'b0;
        end else begin
            v  = $signed(out_d);
            hs = OUT_VALID && OUT_READY;
            if (OUT_VALID) begin
                chk("in_ready_low_while_output", int'(IN_READY), 0);
                chk("output_was_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    chk(out_idx ? "out_imag" : "out_real", v, exp_q[0]);
                    if (hs) begin
                        void'(exp_q.pop_front());
                        if (!out_idx) got_re = v;
                        else got_im = v;
                        done_cnt++;
                    end
                end
                if (!prev_valid) first_valid_cyc = cyc;
                valid_cycles++;
            end else begin
                chk("out_zero_when_invalid", v, 0);
                chk("valid_dropped_while_stalled", int'(prev_stall), 0);
                chk("imag_follows_real_accept", int'(prev_hs_re), 0);
            end
            prev_hs_re = hs && !out_idx;
            if (hs) out_idx = !out_idx;
            prev_stall = OUT_VALID && !OUT_READY;
            prev_valid = OUT_VALID;
        end
    end

    task automatic send_word(input int w, input logic [1:0] m, input int gap,
                             output int acc_cyc);
        int n;
        IN_VALID = 1'b0;
        in_d     = 8'hA5;
        MODE     = ~m;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        IN_VALID = 1'b1;
        in_d     = w[7:0];
        MODE     = m;
        n = 0;
        @(negedge clk);
        while (!IN_READY && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!IN_READY) chk("in_ready_wait", int'(IN_READY), 1);
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        IN_VALID = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("frame_completed", done_cnt, target);
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        while (!OUT_VALID && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_seen", int'(OUT_VALID), 1);
    endtask

    task automatic run_frame(input logic [1:0] m, input logic [1:0] m_late,
                             input int ar, input int ai, input int br, input int bi,
                             input int g2, input int g3, input int g4,
                             input bit junk_in, input int stall,
                             output int c1, output int lat);
        int re, im, c, target;
        model(int'(m), ar, ai, br, bi, re, im);
        exp_q.push_back(re);
        exp_q.push_back(im);
        target          = done_cnt + 2;
        valid_cycles    = 0;
        first_valid_cyc = -1;
        if (stall > 0) OUT_READY = 1'b0;
        send_word(ar, m, 0, c1);
        send_word(ai, m_late, g2, c);
        send_word(br, m_late, g3, c);
        send_word(bi, m_late, g4, c);
        if (junk_in) begin
            IN_VALID = 1'b1;
            in_d     = 8'h7F;
            MODE     = 2'b11;
        end
        if (stall > 0) begin
            wait_out_valid();
            repeat (stall) @(negedge clk);
            chk("in_ready_during_stall", int'(IN_READY), 0);
            @(posedge clk);
            #1;
            OUT_READY = 1'b1;
        end
        wait_done(target);
        chk("in_ready_after_imag", int'(IN_READY), 1);
        IN_VALID = 1'b0;
        lat = first_valid_cyc - c;
    endtask

    initial begin
        int c1, lat, c, rst_cyc;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", int'(OUT_VALID), 0);
        chk("reset_out", int'(out_d), 0);
        chk("reset_in_ready", int'(IN_READY), 1);
        rst = 1'b0;
        rst_cyc = cyc;

        // add 3,4,1,-2 -> 4, 2; first word on first edge after reset
        run_frame(2'b00, 2'b00, 3, 4, 1, -2, 0, 0, 0, 1'b0, 0, c1, lat);
        chk("add_re", got_re, 4);
        chk("add_im", got_im, 2);
        chk("add_latency", lat, 3);
        chk("add_valid_cycles", valid_cycles, 2);
        chk("first_word_after_reset", c1, rst_cyc + 1);

        // sub 3,4,1,-2 -> 2, 6
        run_frame(2'b01, 2'b01, 3, 4, 1, -2, 0, 0, 0, 1'b0, 0, c1, lat);
        chk("sub_re", got_re, 2);
        chk("sub_im", got_im, 6);
        chk("sub_latency", lat, 3);

        // mul 3,4,1,-2 -> 11, -2
        run_frame(2'b10, 2'b10, 3, 4, 1, -2, 0, 0, 0, 1'b0, 0, c1, lat);
        chk("mul_re", got_re, 11);
        chk("mul_im", got_im, -2);
        chk("mul_latency", lat, 5);
        chk("mul_valid_cycles", valid_cycles, 2);

        // mul 3,4,1,2 -> -5, 10
        run_frame(2'b10, 2'b10, 3, 4, 1, 2, 0, 0, 0, 1'b0, 0, c1, lat);
        chk("mul2_re", got_re, -5);
        chk("mul2_im", got_im, 10);

        // conj-mul 3,4,1,2 = (3+4j)(1-2j) -> 11, -2
        run_frame(2'b11, 2'b11, 3, 4, 1, 2, 0, 0, 0, 1'b0, 0, c1, lat);
        chk("cmul_re", got_re, 11);
        chk("cmul_im", got_im, -2);
        chk("cmul_latency", lat, 5);

        // mul of most-negative values -> 0, 32768
        run_frame(2'b10, 2'b10, -128, -128, -128, -128, 0, 0, 0, 1'b0, 0, c1, lat);
        chk("mul_min_re", got_re, 0);
        chk("mul_min_im", got_im, 32768);

        // conj-mul extremes -> 128, -32640
        run_frame(2'b11, 2'b11, -128, 127, -128, -128, 0, 0, 0, 1'b0, 0, c1, lat);
        chk("cmul_ext_re", got_re, 128);
        chk("cmul_ext_im", got_im, -32640);

        // IN_VALID 1,0,0,1,0,1,1; MODE flipped to mul after word 1; junk
        // words offered during CALC/OUT -> still add 10,-20,5,7 -> 15, -13
        run_frame(2'b00, 2'b10, 10, -20, 5, 7, 2, 1, 0, 1'b1, 0, c1, lat);
        chk("gap_re", got_re, 15);
        chk("gap_im", got_im, -13);
        chk("gap_latency", lat, 3);

        // Real part stalled 10 cycles: mul 2,3,4,5 -> -7, 22
        run_frame(2'b10, 2'b10, 2, 3, 4, 5, 0, 0, 0, 1'b0, 9, c1, lat);
        chk("stall_re", got_re, -7);
        chk("stall_im", got_im, 22);

        // Reset while a result is pending: it must never appear
        exp_q.push_back(2);
        exp_q.push_back(2);
        OUT_READY = 1'b0;
        send_word(1, 2'b00, 0, c);
        send_word(1, 2'b00, 0, c);
        send_word(1, 2'b00, 0, c);
        send_word(1, 2'b00, 0, c);
        wait_out_valid();
        #2 rst = 1'b1;
        #1;
        chk("pending_reset_out_valid", int'(OUT_VALID), 0);
        chk("pending_reset_out", int'(out_d), 0);
        chk("pending_reset_in_ready", int'(IN_READY), 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        OUT_READY = 1'b1;

        // Reset mid-edge after word 2, then a full add frame
        send_word(9, 2'b10, 0, c);
        send_word(9, 2'b10, 0, c);
        #3 rst = 1'b1;
        #1;
        chk("midload_reset_out_valid", int'(OUT_VALID), 0);
        chk("midload_reset_in_ready", int'(IN_READY), 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rst_cyc = cyc;
        run_frame(2'b00, 2'b00, 3, 4, 1, -2, 0, 0, 0, 1'b0, 0, c1, lat);
        chk("after_reset_re", got_re, 4);
        chk("after_reset_im", got_im, 2);
        chk("after_reset_first_word", c1, rst_cyc + 1);

        repeat (8) @(posedge clk);
        #1;
        chk("no_leftover_results", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
